// File: rtl/gen_tick_ctrl.sv
// gen_tick_ctrl: generation-rate controller producing a per-generation tick, a legacy slow clock and run/step/speed command handling
module gen_tick_ctrl #(
  parameter int CNT_W         = 32,
  parameter int BASE_DIV      = 187_500,
  parameter int NUM_SPEEDS    = 4,
  parameter int SPD_W         = 2,
  parameter int INIT_SPEED    = 0,
  parameter int START_RUNNING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       usr_op,
  output logic             tick,
  output logic             clk_out,
  output logic             running,
  output logic [SPD_W-1:0] speed
);
  typedef enum logic {RUNNING, PAUSED} state_t;
  localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_DIV);
  localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(NUM_SPEEDS - 1);
  localparam state_t           INIT_ST = (START_RUNNING != 0) ? RUNNING : PAUSED;
  state_t           state;
  logic [3:0]       prev, op_edge;
  logic [CNT_W-1:0] cnt, limit;
  logic             up, dn, tc, step, fire;
  // command edges, current period limit and the tick/speed decisions for this cycle
  always_comb begin
    op_edge = usr_op & ~prev;
    limit   = (BASE << (MAX_SPD - speed)) - CNT_W'(1);
    up      = op_edge[2] & ~op_edge[3] & (speed != MAX_SPD);
    dn      = op_edge[3] & ~op_edge[2] & (speed != '0);
    tc      = (state == RUNNING) & (cnt == limit);
    step    = (state == PAUSED) & op_edge[1] & ~op_edge[0];
    fire    = tc | step;
  end
  // run/pause state, period counter, speed level and registered tick outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT_ST;
      running <= INIT_ST == RUNNING;
      prev    <= '0;
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      speed   <= SPD_W'(INIT_SPEED);
    end else begin
      prev <= usr_op;
      tick <= fire;
      if (fire) clk_out <= ~clk_out;
      if (op_edge[0]) begin
        state   <= (state == RUNNING) ? PAUSED : RUNNING;
        running <= state != RUNNING;
      end
      if (up) speed <= speed + 1'b1;
      else if (dn) speed <= speed - 1'b1;
      cnt <= (op_edge[0] | up | dn | tc | (state == PAUSED)) ? '0 : cnt + 1'b1;
    end
  end
endmodule
